// File: rtl/dota_channel_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dota_pkg
// Brief    : Shared types and constants for the OTA channel sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package dota_pkg;

  // Conversion FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  // Width of sample and ones counters; N_SAMP is at most 15
  localparam int SAMP_CNT_W = 4;

  // Channel index width for a given channel count
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dota_channel_sequencer_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dota_rr_arbiter
// Brief    : Combinational round-robin pick: first requesting channel at or
//            after the pointer, wrapping modulo N_CH.
// Revision : 1.0 - initial release
// ============================================================================
module dota_rr_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] grant,
  output logic            any
);

  logic [CH_W:0]   w_sum;
  logic [CH_W-1:0] w_idx;

  // Scan channels starting at the pointer; the first hit wins
  always_comb begin
    grant = '0;
    any   = 1'b0;
    w_sum = '0;
    w_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_sum = {1'b0, ptr} + (CH_W + 1)'(i);
      if (w_sum >= (CH_W + 1)'(N_CH)) begin
        w_sum = w_sum - (CH_W + 1)'(N_CH);
      end
      w_idx = w_sum[CH_W-1:0];
      if (!any && req[w_idx]) begin
        any   = 1'b1;
        grant = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dota_channel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dota_channel_sequencer
// Brief    : Time-multiplexes one OTA comparator across N_CH channels:
//            round-robin grant, settle, majority-vote N_SAMP synchronized
//            samples, and present the decision over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module dota_channel_sequencer
  import dota_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int SETTLE_CYC = 8,
  parameter int N_SAMP     = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [N_CH-1:0]         req,
  output logic [N_CH-1:0]         sel,
  output logic                    ota_en,
  input  logic                    ota_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [$clog2(N_CH)-1:0] res_ch,
  output logic                    res_bit,
  output logic                    busy
);

  localparam int c_ch_w  = $clog2(N_CH);
  localparam int c_set_w = $clog2(SETTLE_CYC);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_ch_w-1:0]     r_ptr;
  logic [c_ch_w-1:0]     r_grant;
  logic [c_ch_w-1:0]     w_arb_idx;
  logic                  w_arb_any;
  logic [c_ch_w-1:0]     w_grant_nxt;
  logic [N_CH-1:0]       w_sel_nxt;
  logic                  w_busy_nxt;
  logic                  w_valid_nxt;
  logic                  r_sync1;
  logic                  r_sync2;
  logic [c_set_w-1:0]    r_set_cnt;
  logic [SAMP_CNT_W-1:0] r_smp_cnt;
  logic [SAMP_CNT_W-1:0] r_ones;
  logic [SAMP_CNT_W:0]   w_ones_total;
  logic                  w_settle_done;
  logic                  w_sample_done;
  logic                  w_majority;

  dota_rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (c_ch_w)
  ) u_arb (
    .req   (req),
    .ptr   (r_ptr),
    .grant (w_arb_idx),
    .any   (w_arb_any)
  );

  assign w_settle_done = (r_set_cnt == c_set_w'(SETTLE_CYC - 1));
  assign w_sample_done = (r_smp_cnt == SAMP_CNT_W'(N_SAMP - 1));
  // The current cycle's sample is folded in so the vote includes the last one
  assign w_ones_total  = {1'b0, r_ones} + {{SAMP_CNT_W{1'b0}}, r_sync2};
  assign w_majority    = (w_ones_total > (SAMP_CNT_W + 1)'(N_SAMP / 2));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; ena only aborts the analog phases, never a pending result
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (ena && w_arb_any) w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (!ena)               w_state_nxt = ST_IDLE;
        else if (w_settle_done) w_state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (!ena)               w_state_nxt = ST_IDLE;
        else if (w_sample_done) w_state_nxt = ST_RESULT;
      end
      ST_RESULT: if (res_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every output can be registered
  always_comb begin
    w_grant_nxt = (r_state == ST_IDLE) ? w_arb_idx : r_grant;
    w_sel_nxt   = '0;
    if (w_state_nxt == ST_SETTLE || w_state_nxt == ST_SAMPLE) begin
      w_sel_nxt = N_CH'(1) << w_grant_nxt;
    end
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_valid_nxt = (w_state_nxt == ST_RESULT);
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= '0;
      ota_en    <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      sel       <= w_sel_nxt;
      ota_en    <= (w_sel_nxt != '0);
      busy      <= w_busy_nxt;
      res_valid <= w_valid_nxt;
    end
  end

  // Grant latch and round-robin pointer advance on each new grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= '0;
      r_ptr   <= '0;
    end else if (r_state == ST_IDLE && w_state_nxt == ST_SETTLE) begin
      r_grant <= w_arb_idx;
      r_ptr   <= (w_arb_idx == c_ch_w'(N_CH - 1)) ? '0 : w_arb_idx + c_ch_w'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous OTA output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= ota_out;
      r_sync2 <= r_sync1;
    end
  end

  // Settle/sample counters and ones accumulator; all idle at zero outside their phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set_cnt <= '0;
      r_smp_cnt <= '0;
      r_ones    <= '0;
    end else begin
      r_set_cnt <= (r_state == ST_SETTLE) ? r_set_cnt + c_set_w'(1) : '0;
      r_smp_cnt <= (r_state == ST_SAMPLE) ? r_smp_cnt + SAMP_CNT_W'(1) : '0;
      r_ones    <= (r_state == ST_SAMPLE) ? w_ones_total[SAMP_CNT_W-1:0] : '0;
    end
  end

  // Capture the decision when the last sample completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_ch  <= '0;
      res_bit <= 1'b0;
    end else if (r_state == ST_SAMPLE && w_state_nxt == ST_RESULT) begin
      res_ch  <= r_grant;
      res_bit <= w_majority;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dota_channel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dota_channel_sequencer
// Brief    : Directed self-checking bench for dota_channel_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dota_channel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       ota_out = 1'b0;
  logic       res_ready = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] sel;
  logic       ota_en;
  logic       res_valid;
  logic       res_bit;
  logic       busy;
  logic [1:0] res_ch;

  int n_checks = 0;
  int n_fail   = 0;
  int multi_hot   = 0;
  int en_mismatch = 0;

  dota_channel_sequencer #(
    .N_CH       (4),
    .SETTLE_CYC (8),
    .N_SAMP     (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req       (req),
    .sel       (sel),
    .ota_en    (ota_en),
    .ota_out   (ota_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_ch    (res_ch),
    .res_bit   (res_bit),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Continuous watch: sel one-hot or zero, ota_en tracks sel
  always @(negedge clk) begin
    if ($countones(sel) > 1) multi_hot++;
    if (ota_en !== (sel != 4'b0000)) en_mismatch++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; ena = 1'b0; ota_out = 1'b0; res_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_sel(input string tag);
    int k = 0;
    while (sel == 4'b0000 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_sel_seen"}, 32'(sel != 4'b0000), 1);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (res_valid !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_valid_seen"}, 32'(res_valid), 1);
  endtask

  // Drive a 5-sample pattern so the synchronized value lines up with SAMPLE
  task automatic conv_pattern(input string tag, input logic [4:0] pat, input logic pre,
                              input logic exp_bit);
    ota_out = pre;
    req = 4'b0001;
    wait_sel(tag);          // cycle T+1
    req = 4'b0000;
    tick(6);                // cycle T+7, two cycles ahead of first SAMPLE
    for (int j = 0; j < 5; j++) begin
      ota_out = pat[4-j];
      tick(1);
    end
    ota_out = pre;
    wait_valid(tag);
    chk({tag, "_ch"}, 32'(res_ch), 0);
    chk({tag, "_bit"}, 32'(res_bit), 32'(exp_bit));
    tick(1);
  endtask

  initial begin
    int hold_bad;
    int stray;
    logic [1:0] exp_seq [5];
    exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2;
    exp_seq[3] = 2'd3; exp_seq[4] = 2'd0;

    // Reset values
    do_reset();
    chk("rst_sel", 32'(sel), 0);
    chk("rst_ota_en", 32'(ota_en), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_busy", 32'(busy), 0);

    // Single channel, constant high OTA, latency check
    ena = 1'b1; res_ready = 1'b1; ota_out = 1'b1; req = 4'b0100;   // cycle T
    tick(1);                                                          // T+1
    chk("t1_sel", 32'(sel), 32'h4);
    chk("t1_ota_en", 32'(ota_en), 1);
    chk("t1_busy", 32'(busy), 1);
    tick(12);                                                         // T+13
    chk("t1_valid_early", 32'(res_valid), 0);
    chk("t1_sel_sample", 32'(sel), 32'h4);
    req = 4'b0000;
    tick(1);                                                          // T+14
    chk("t1_valid", 32'(res_valid), 1);
    chk("t1_ch", 32'(res_ch), 2);
    chk("t1_bit", 32'(res_bit), 1);
    chk("t1_sel_result", 32'(sel), 0);
    tick(1);                                                          // T+15
    chk("t1_valid_drop", 32'(res_valid), 0);
    chk("t1_busy_idle", 32'(busy), 0);

    // Round-robin across all channels from reset
    do_reset();
    ena = 1'b1; res_ready = 1'b1; ota_out = 1'b0; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_valid("t2");
      chk($sformatf("t2_order%0d", i), 32'(res_ch), 32'(exp_seq[i]));
      if (i == 0) chk("t2_bit", 32'(res_bit), 0);
      tick(1);
    end
    req = 4'b0000;
    tick(20);

    // Majority vote on aligned sample patterns
    conv_pattern("t3a", 5'b10100, 1'b1, 1'b0);
    conv_pattern("t3b", 5'b11010, 1'b0, 1'b1);

    // Back-pressure: result held while res_ready low
    do_reset();
    ena = 1'b1; res_ready = 1'b0; ota_out = 1'b1; req = 4'b1111;
    wait_valid("t4");
    chk("t4_ch", 32'(res_ch), 0);
    chk("t4_bit", 32'(res_bit), 1);
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (res_valid !== 1'b1 || res_ch !== 2'd0 || res_bit !== 1'b1 ||
          sel !== 4'b0000 || busy !== 1'b1) hold_bad++;
    end
    chk("t4_hold", 32'(hold_bad), 0);
    res_ready = 1'b1;                                                 // cycle A
    tick(1);                                                          // A+1
    chk("t4_valid_drop", 32'(res_valid), 0);
    chk("t4_busy_idle", 32'(busy), 0);
    chk("t4_sel_idle", 32'(sel), 0);
    tick(1);                                                          // A+2
    chk("t4_next_grant", 32'(sel), 32'h2);
    req = 4'b0000;

    // ena dropped during SAMPLE aborts; pointer keeps advanced value
    do_reset();
    ena = 1'b1; res_ready = 1'b1; ota_out = 1'b1; req = 4'b0100;   // T
    tick(1);                                                          // T+1
    req = 4'b0000;
    tick(9);                                                          // T+10, SAMPLE
    ena = 1'b0;
    tick(1);                                                          // T+11
    chk("t5_sel", 32'(sel), 0);
    chk("t5_ota_en", 32'(ota_en), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_valid", 32'(res_valid), 0);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (res_valid !== 1'b0) stray++;
    end
    chk("t5_no_result", 32'(stray), 0);
    ena = 1'b1; req = 4'b1101;
    tick(1);
    chk("t5_ptr_grant", 32'(sel), 32'h8);
    req = 4'b0000;
    wait_valid("t5b");
    chk("t5_ch3", 32'(res_ch), 3);
    tick(1);
    req = 4'b0001;
    wait_sel("t5c");
    chk("t5_sel0", 32'(sel), 32'h1);
    req = 4'b0000;
    wait_valid("t5c");
    chk("t5_ch0", 32'(res_ch), 0);
    tick(1);

    // Asynchronous reset in mid-SETTLE
    ena = 1'b1; res_ready = 1'b1; req = 4'b0010;
    tick(1);
    chk("t6_sel_pre", 32'(sel), 32'h2);
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_sel", 32'(sel), 0);
    chk("t6_ota_en", 32'(ota_en), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_valid", 32'(res_valid), 0);
    chk("t6_ch", 32'(res_ch), 0);
    chk("t6_bit", 32'(res_bit), 0);
    req = 4'b0000;
    tick(1);
    rst_n = 1'b1;
    tick(2);

    chk("onehot_sel", 32'(multi_hot), 0);
    chk("ota_en_tracks_sel", 32'(en_mismatch), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
